// File: rtl/dmem_store_buffer.sv
// Store buffer between the MEM/WB store stream and the data-memory bus.
// Stores are queued in a small circular FIFO, drained one at a time through
// a req/ack bus handshake, and forwarded combinationally to matching loads.
module dmem_store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_mem_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    output logic                  o_load_hit,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
    output logic                  o_bus_req,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    input  logic                  i_bus_ack
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;

    logic                  w_full;
    logic                  w_enq;
    logic                  w_pop;
    logic                  w_start;
    logic                  w_bus_req;
    logic                  w_load_hit;
    logic [DATA_WIDTH-1:0] w_load_data;

    // Full is judged on the pre-edge count, so an ack in the same cycle
    // frees a slot only for the following cycle's store.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_enq   = i_mem_write && !w_full;
    assign w_pop   = (r_state == S_REQ) && i_bus_ack;
    assign w_start = (r_state == S_IDLE) && (r_count != '0);

    // Entry payload storage, written at the tail on every accepted store.
    // NOTE: payload RAM has no reset; occupancy is tracked by r_valid/r_count,
    // so stale contents are never observable and the array maps onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_wr_ptr] <= i_addr;
            r_data[r_wr_ptr] <= i_write_data;
        end
    end

    // FIFO bookkeeping: pointers, occupancy count, per-entry valid bits.
    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr          <= r_rd_ptr + 1'b1;
                r_valid[r_rd_ptr] <= 1'b0;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag: any store presented while the buffer is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_mem_write && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Bus FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bus FSM next-state and request output.
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_bus_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_bus_req = 1'b1;
                if (i_bus_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bus address/data: capture the head entry when a request starts and
    // hold it through the request and the following idle period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else if (w_start) begin
            r_bus_addr  <= r_addr[r_rd_ptr];
            r_bus_wdata <= r_data[r_rd_ptr];
        end
    end

    // Load forwarding: scan occupied entries oldest to youngest so the last
    // match (closest to the tail) wins; the head stays visible until popped.
    always_comb begin
        w_load_hit  = 1'b0;
        w_load_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[r_rd_ptr + PTR_W'(i)] &&
                (r_addr[r_rd_ptr + PTR_W'(i)] == i_load_addr)) begin
                w_load_hit  = 1'b1;
                w_load_data = r_data[r_rd_ptr + PTR_W'(i)];
            end
        end
    end

    assign o_full      = w_full;
    assign o_empty     = (r_count == '0) && (r_state == S_IDLE);
    assign o_overflow  = r_overflow;
    assign o_bus_req   = w_bus_req;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_load_hit  = w_load_hit;
    assign o_load_data = w_load_data;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: directed vector table,
// hand-written multi-cycle corner cases and a randomized run against a
// queue-based reference model.
module tb_dmem_store_buffer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          i_mem_write;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_write_data;
    logic [AW-1:0] i_load_addr;
    logic          o_load_hit;
    logic [DW-1:0] o_load_data;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;
    logic          o_bus_req;
    logic [AW-1:0] o_bus_addr;
    logic [DW-1:0] o_bus_wdata;
    logic          i_bus_ack;

    dmem_store_buffer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_write (i_mem_write),
        .i_addr      (i_addr),
        .i_write_data(i_write_data),
        .i_load_addr (i_load_addr),
        .o_load_hit  (o_load_hit),
        .o_load_data (o_load_data),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_overflow  (o_overflow),
        .o_bus_req   (o_bus_req),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (i_bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [AW-1:0] la, input logic ack);
        i_mem_write  = wr;
        i_addr       = a;
        i_write_data = d;
        i_load_addr  = la;
        i_bus_ack    = ack;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;

    st_t           mq[$];
    bit            m_req;
    bit            m_ovf;
    logic [AW-1:0] m_baddr;
    logic [DW-1:0] m_bdata;

    task automatic model_reset();
        mq.delete();
        m_req   = 1'b0;
        m_ovf   = 1'b0;
        m_baddr = '0;
        m_bdata = '0;
    endtask

    // Applies one clock edge using the values that were present before it.
    task automatic model_edge(input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic ack);
        bit full  = (mq.size() == DEPTH);
        bit pop   = m_req && ack;
        bit start = !m_req && (mq.size() != 0);
        st_t e;
        if (start) begin
            m_req   = 1'b1;
            m_baddr = mq[0].a;
            m_bdata = mq[0].d;
        end
        if (pop) begin
            void'(mq.pop_front());
            m_req = 1'b0;
        end
        if (wr) begin
            if (full) begin
                m_ovf = 1'b1;
            end else begin
                e.a = a;
                e.d = d;
                mq.push_back(e);
            end
        end
    endtask

    task automatic model_check();
        logic          hit = 1'b0;
        logic [DW-1:0] ld  = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == i_load_addr) begin
                hit = 1'b1;
                ld  = mq[i].d;
                break;
            end
        end
        check("rnd_req",   32'(o_bus_req),  32'(m_req));
        check("rnd_full",  32'(o_full),     32'(mq.size() == DEPTH));
        check("rnd_empty", 32'(o_empty),    32'(mq.size() == 0 && !m_req));
        check("rnd_ovf",   32'(o_overflow), 32'(m_ovf));
        check("rnd_hit",   32'(o_load_hit), 32'(hit));
        check("rnd_ldata", o_load_data,     ld);
        if (m_req) begin
            check("rnd_baddr", o_bus_addr,  m_baddr);
            check("rnd_bdata", o_bus_wdata, m_bdata);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW-1:0] load;
        logic          ack;
        logic          e_req;
        logic          e_full;
        logic          e_empty;
        logic          e_ovf;
        logic          e_hit;
        logic [DW-1:0] e_ldata;
        logic [AW-1:0] e_baddr;
        logic [DW-1:0] e_bdata;
    } vec_t;

    vec_t vecs[12];

    task automatic do_reset();
        set_in(1'b0, '0, '0, '0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill(input int n, input logic [AW-1:0] base);
        for (int i = 0; i < n; i++) begin
            set_in(1'b1, base + AW'(i), 32'hA0 + DW'(i), '0, 1'b0);
            tick();
        end
        set_in(1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        int reqs;
        int cyc_at[$];
        logic [AW-1:0] addr_at[$];
        logic [DW-1:0] data_at[$];

        // Outputs are checked before the edge that applies each row's inputs.
        //            wr    addr      data        load      ack   req   full  empty ovf   hit   ldata       baddr     bdata
        vecs[0]  = '{1'b1, 32'h10, 32'hCAFE, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,  32'h0};
        vecs[1]  = '{1'b0, 32'h0,  32'h0,    32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE, 32'h0,  32'h0};
        vecs[2]  = '{1'b0, 32'h0,  32'h0,    32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE, 32'h10, 32'hCAFE};
        vecs[3]  = '{1'b0, 32'h0,  32'h0,    32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h10, 32'hCAFE};
        vecs[4]  = '{1'b1, 32'h20, 32'h1,    32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h10, 32'hCAFE};
        vecs[5]  = '{1'b1, 32'h20, 32'h2,    32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1,    32'h10, 32'hCAFE};
        vecs[6]  = '{1'b0, 32'h0,  32'h0,    32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2,    32'h20, 32'h1};
        vecs[7]  = '{1'b0, 32'h0,  32'h0,    32'h24, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h20, 32'h1};
        vecs[8]  = '{1'b0, 32'h0,  32'h0,    32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2,    32'h20, 32'h1};
        vecs[9]  = '{1'b0, 32'h0,  32'h0,    32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2,    32'h20, 32'h1};
        vecs[10] = '{1'b0, 32'h0,  32'h0,    32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2,    32'h20, 32'h2};
        vecs[11] = '{1'b0, 32'h0,  32'h0,    32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h20, 32'h2};

        // Test 1: reset and idle.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            check("idle_empty", 32'(o_empty),   32'd1);
            check("idle_req",   32'(o_bus_req), 32'd0);
            check("idle_full",  32'(o_full),    32'd0);
            tick();
        end
        check("rst_ovf",   32'(o_overflow),  32'd0);
        check("rst_hit",   32'(o_load_hit),  32'd0);
        check("rst_ldata", o_load_data,      32'd0);
        check("rst_baddr", o_bus_addr,       32'd0);
        check("rst_bdata", o_bus_wdata,      32'd0);

        // Tests 2 and 4: single store latency, then youngest-match forwarding.
        do_reset();
        for (int v = 0; v < 12; v++) begin
            set_in(vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].load, vecs[v].ack);
            #1;
            check($sformatf("vec%0d_req", v),   32'(o_bus_req),  32'(vecs[v].e_req));
            check($sformatf("vec%0d_full", v),  32'(o_full),     32'(vecs[v].e_full));
            check($sformatf("vec%0d_empty", v), 32'(o_empty),    32'(vecs[v].e_empty));
            check($sformatf("vec%0d_ovf", v),   32'(o_overflow), 32'(vecs[v].e_ovf));
            check($sformatf("vec%0d_hit", v),   32'(o_load_hit), 32'(vecs[v].e_hit));
            check($sformatf("vec%0d_ldata", v), o_load_data,     vecs[v].e_ldata);
            check($sformatf("vec%0d_baddr", v), o_bus_addr,      vecs[v].e_baddr);
            check($sformatf("vec%0d_bdata", v), o_bus_wdata,     vecs[v].e_bdata);
            @(posedge clk);
            #1;
        end

        // Test 3: fill, overflow, in-order drain at one store per 2 cycles.
        do_reset();
        fill(DEPTH, 32'h100);
        #1;
        check("fill_full",  32'(o_full),     32'd1);
        check("fill_req",   32'(o_bus_req),  32'd1);
        check("fill_baddr", o_bus_addr,      32'h100);
        check("fill_ovf0",  32'(o_overflow), 32'd0);
        set_in(1'b1, 32'h1FF, 32'hDEAD, 32'h1FF, 1'b0);
        tick();
        set_in(1'b0, '0, '0, 32'h1FF, 1'b1);
        #1;
        check("ovf_set",  32'(o_overflow), 32'd1);
        check("ovf_full", 32'(o_full),     32'd1);
        check("ovf_nohit", 32'(o_load_hit), 32'd0);
        for (int c = 0; c < 20; c++) begin
            if (o_bus_req) begin
                cyc_at.push_back(c);
                addr_at.push_back(o_bus_addr);
                data_at.push_back(o_bus_wdata);
            end
            tick();
            #1;
        end
        check("drain_count", 32'(cyc_at.size()), 32'(DEPTH));
        for (int i = 0; i < cyc_at.size() && i < DEPTH; i++) begin
            check($sformatf("drain%0d_addr", i), addr_at[i], 32'h100 + 32'(i));
            check($sformatf("drain%0d_data", i), data_at[i], 32'hA0 + 32'(i));
            check($sformatf("drain%0d_cyc", i), 32'(cyc_at[i]), 32'(2 * i));
        end
        check("drain_empty",  32'(o_empty),    32'd1);
        check("drain_ovf",    32'(o_overflow), 32'd1);

        // Test 5: full buffer, ack and store in the same cycle.
        do_reset();
        fill(DEPTH, 32'h100);
        set_in(1'b1, 32'h55, 32'h5555, '0, 1'b1);
        tick();
        set_in(1'b0, '0, '0, 32'h55, 1'b0);
        #1;
        check("same_full",  32'(o_full),     32'd0);
        check("same_ovf",   32'(o_overflow), 32'd1);
        check("same_hit55", 32'(o_load_hit), 32'd0);
        check("same_req",   32'(o_bus_req),  32'd0);
        i_load_addr = 32'h101;
        #1;
        check("same_hit101",  32'(o_load_hit), 32'd1);
        check("same_data101", o_load_data,     32'hA1);
        i_load_addr = 32'h100;
        #1;
        check("same_hit100", 32'(o_load_hit), 32'd0);
        i_bus_ack = 1'b1;
        reqs = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (o_bus_req) reqs++;
            tick();
        end
        check("same_drained", 32'(reqs), 32'(DEPTH - 1));

        // Test 6: asynchronous reset in the middle of a request.
        do_reset();
        fill(3, 32'h200);
        #1;
        check("mid_req_pre", 32'(o_bus_req), 32'd1);
        i_load_addr = 32'h200;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_req",   32'(o_bus_req),  32'd0);
        check("mid_empty", 32'(o_empty),    32'd1);
        check("mid_full",  32'(o_full),     32'd0);
        check("mid_hit",   32'(o_load_hit), 32'd0);
        check("mid_baddr", o_bus_addr,      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reqs = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (o_bus_req || !o_empty) reqs++;
        end
        check("mid_after", 32'(reqs), 32'd0);

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic          wr  = ($urandom_range(0, 2) != 0);
            logic [AW-1:0] a   = 32'h40 + 32'($urandom_range(0, 7));
            logic [DW-1:0] d   = $urandom;
            logic [AW-1:0] la  = 32'h40 + 32'($urandom_range(0, 8));
            logic          ack = ($urandom_range(0, 1) != 0);
            set_in(wr, a, d, la, ack);
            #1;
            model_check();
            @(posedge clk);
            model_edge(wr, a, d, ack);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
